// File: rtl/bht_sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bht_pkg
// Purpose  : Shared constants, FSM state type and counter-update helper for
//            the branch history table SRAM controller.
// Contents : DEPTH / IDX_W / CTR_W / INIT_CTR, bht_state_e, ctr_next()
// Revision : 1.0 - initial release
// ============================================================================
package bht_pkg;

  localparam int DEPTH = 32;
  localparam int IDX_W = 5;
  localparam int CTR_W = 2;
  localparam logic [CTR_W-1:0] INIT_CTR = 2'b01;  // weakly not-taken

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    DRAIN = 2'd2,
    RUN   = 2'd3
  } bht_state_e;

  // Two-bit saturating counter step: up on taken, down on not-taken,
  // clamped at both ends.
  function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] ctr,
                                                 input logic             taken);
    logic [CTR_W-1:0] r;
    r = ctr;
    if (taken) begin
      if (ctr != '1) r = ctr + CTR_W'(1);
    end else begin
      if (ctr != '0) r = ctr - CTR_W'(1);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bht_sram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bht_sram_ctrl_if
// Purpose  : Frontend/ROB-side bundle of the BHT controller: prediction
//            lookup request/response, counter update handshake and the
//            table-initialized flag.
// Modports : master - requester side (frontend + commit)
//            slave  - controller side
// Revision : 1.0 - initial release
// ============================================================================
interface bht_sram_ctrl_if;
  import bht_pkg::*;

  logic             pred_req_valid;
  logic [IDX_W-1:0] pred_req_idx;
  logic             pred_rsp_valid;
  logic [CTR_W-1:0] pred_rsp_ctr;
  logic             pred_rsp_taken;
  logic             upd_valid;
  logic             upd_ready;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             init_done;

  modport master (
    output pred_req_valid, pred_req_idx, upd_valid, upd_idx, upd_taken,
    input  pred_rsp_valid, pred_rsp_ctr, pred_rsp_taken, upd_ready, init_done
  );

  modport slave (
    input  pred_req_valid, pred_req_idx, upd_valid, upd_idx, upd_taken,
    output pred_rsp_valid, pred_rsp_ctr, pred_rsp_taken, upd_ready, init_done
  );

endinterface
`default_nettype wire

// File: rtl/bht_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bht_sram_ctrl
// Purpose  : Controller for the 32 x 2-bit dual-port BHT macro. Sweeps the
//            table to INIT_CTR after reset, serves predictions on port 0 and
//            commit-stage read-modify-write updates on port 1, forwarding the
//            most recent write to reads that would otherwise see stale data.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            bus (slave)     - prediction / update / init_done bundle
//            sram_*0         - macro port 0 controls and read data
//            sram_*1         - macro port 1 controls and read data
// Revision : 1.0 - initial release
// ============================================================================
module bht_sram_ctrl
  import bht_pkg::*;
(
  input  wire              clk,
  input  wire              rst_n,
  bht_sram_ctrl_if.slave   bus,
  output logic             sram_csb0,
  output logic             sram_web0,
  output logic [IDX_W-1:0] sram_addr0,
  output logic [CTR_W-1:0] sram_din0,
  input  wire  [CTR_W-1:0] sram_dout0,
  output logic             sram_csb1,
  output logic             sram_web1,
  output logic [IDX_W-1:0] sram_addr1,
  output logic [CTR_W-1:0] sram_din1,
  input  wire  [CTR_W-1:0] sram_dout1
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  bht_state_e       state;
  bht_state_e       state_nxt;
  logic [IDX_W-1:0] init_cnt;

  // Update pipeline stage U1 (write-back pending)
  logic             u1_valid;
  logic [IDX_W-1:0] u1_idx;
  logic             u1_taken;

  // Prediction read in flight (response next cycle)
  logic             p_valid;
  logic [IDX_W-1:0] p_idx;

  // Last port 1 write, used to bypass the macro's write-to-read latency
  logic             wb_valid;
  logic [IDX_W-1:0] wb_idx;
  logic [CTR_W-1:0] wb_val;

  logic             p1_wr;
  logic             upd_fire;
  logic [CTR_W-1:0] u1_old;
  logic [CTR_W-1:0] u1_new;
  logic [CTR_W-1:0] pred_ctr;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // --------------------------------------------------------------------------
  // Next state and macro controls
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    sram_csb0  = 1'b1;
    sram_web0  = 1'b1;
    sram_addr0 = '0;
    sram_din0  = '0;
    sram_csb1  = 1'b1;
    sram_web1  = 1'b1;
    sram_addr1 = '0;
    sram_din1  = '0;
    p1_wr      = 1'b0;
    upd_fire   = 1'b0;

    case (state)
      IDLE: state_nxt = INIT;

      INIT: begin
        sram_csb1  = 1'b0;
        sram_web1  = 1'b0;
        sram_addr1 = init_cnt;
        sram_din1  = INIT_CTR;
        p1_wr      = 1'b1;
        if (init_cnt == LAST_IDX) state_nxt = DRAIN;
      end

      DRAIN: state_nxt = RUN;

      RUN: begin
        if (bus.pred_req_valid) begin
          sram_csb0  = 1'b0;
          sram_addr0 = bus.pred_req_idx;
        end
        // A pending write-back owns port 1; a new update is only accepted
        // when the port is free, which is exactly what upd_ready advertises.
        if (u1_valid) begin
          sram_csb1  = 1'b0;
          sram_web1  = 1'b0;
          sram_addr1 = u1_idx;
          sram_din1  = u1_new;
          p1_wr      = 1'b1;
        end else if (bus.upd_valid) begin
          upd_fire   = 1'b1;
          sram_csb1  = 1'b0;
          sram_addr1 = bus.upd_idx;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt <= '0;
      u1_valid <= 1'b0;
      u1_idx   <= '0;
      u1_taken <= 1'b0;
      p_valid  <= 1'b0;
      p_idx    <= '0;
      wb_valid <= 1'b0;
      wb_idx   <= '0;
      wb_val   <= '0;
    end else begin
      init_cnt <= (state == INIT) ? init_cnt + IDX_W'(1) : '0;

      u1_valid <= upd_fire;
      if (upd_fire) begin
        u1_idx   <= bus.upd_idx;
        u1_taken <= bus.upd_taken;
      end

      p_valid <= (state == RUN) && bus.pred_req_valid;
      if ((state == RUN) && bus.pred_req_valid) p_idx <= bus.pred_req_idx;

      wb_valid <= p1_wr;
      if (p1_wr) begin
        wb_idx <= sram_addr1;
        wb_val <= sram_din1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read-data resolution with write-back bypass
  // --------------------------------------------------------------------------
  always_comb begin
    u1_old = (wb_valid && (wb_idx == u1_idx)) ? wb_val : sram_dout1;
    u1_new = ctr_next(u1_old, u1_taken);
    pred_ctr = '0;
    if (p_valid) pred_ctr = (wb_valid && (wb_idx == p_idx)) ? wb_val : sram_dout0;
  end

  assign bus.pred_rsp_valid = p_valid;
  assign bus.pred_rsp_ctr   = pred_ctr;
  assign bus.pred_rsp_taken = pred_ctr[CTR_W-1];
  assign bus.upd_ready      = (state == RUN) && !u1_valid;
  assign bus.init_done      = (state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_bht_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bht_sram_ctrl
// Purpose  : Self-checking bench for bht_sram_ctrl. Includes a behavioural
//            model of the dual-port macro (read-first on same-edge
//            collisions, random power-up contents) and a counter-array
//            reference model checked every cycle, plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bht_sram_ctrl;
  import bht_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sram_csb0, sram_web0, sram_csb1, sram_web1;
  logic [4:0] sram_addr0, sram_addr1;
  logic [1:0] sram_din0, sram_din1;
  logic [1:0] sram_dout0, sram_dout1;

  bht_sram_ctrl_if bus ();

  bht_sram_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0),
    .sram_csb1  (sram_csb1),
    .sram_web1  (sram_web1),
    .sram_addr1 (sram_addr1),
    .sram_din1  (sram_din1),
    .sram_dout1 (sram_dout1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Macro model: no reset, random contents at power-up. Same-edge read of a
  // location being written returns the old data.
  logic [1:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 2'($urandom_range(0, 3));
    sram_dout0 = 2'($urandom_range(0, 3));
    sram_dout1 = 2'($urandom_range(0, 3));
    forever begin
      @(posedge clk);
      if (!sram_csb0) sram_dout0 <= mem[sram_addr0];
      if (!sram_csb1) begin
        if (!sram_web1) mem[sram_addr1] <= sram_din1;
        else            sram_dout1 <= mem[sram_addr1];
      end
    end
  end

  // Clock edges seen since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)               edge_cnt <= 0;
    else if (edge_cnt < 1000) edge_cnt <= edge_cnt + 1;
  end

  // --------------------------------------------------------------------------
  // Reference model and per-cycle compare
  // --------------------------------------------------------------------------
  logic [1:0] model [32];
  bit         acc_prev = 1'b0;
  logic [4:0] prev_idx = '0;
  bit         exp_rv = 1'b0;
  logic [1:0] exp_rc = '0;

  function automatic logic [1:0] sat(input logic [1:0] v, input logic tk);
    int n;
    n = int'(v) + (tk ? 1 : -1);
    if (n > 3) n = 3;
    if (n < 0) n = 0;
    return 2'(n);
  endfunction

  always @(negedge clk) begin
    bit run, rdy, acc;
    if (!rst_n) begin
      chk("rst_rsp_valid", int'(bus.pred_rsp_valid), 0);
      chk("rst_rsp_ctr",   int'(bus.pred_rsp_ctr),   0);
      chk("rst_upd_ready", int'(bus.upd_ready),      0);
      chk("rst_init_done", int'(bus.init_done),      0);
      chk("rst_csb0",      int'(sram_csb0),          1);
      chk("rst_csb1",      int'(sram_csb1),          1);
      chk("rst_web1",      int'(sram_web1),          1);
      for (int i = 0; i < 32; i++) model[i] = INIT_CTR;
      acc_prev = 1'b0;
      exp_rv   = 1'b0;
    end else begin
      run = (edge_cnt >= 34);
      rdy = run && !acc_prev;
      acc = rdy && bus.upd_valid;
      chk("init_done", int'(bus.init_done), int'(run));
      chk("upd_ready", int'(bus.upd_ready), int'(rdy));
      chk("rsp_valid", int'(bus.pred_rsp_valid), int'(exp_rv));
      if (exp_rv) begin
        chk("rsp_ctr",   int'(bus.pred_rsp_ctr),   int'(exp_rc));
        chk("rsp_taken", int'(bus.pred_rsp_taken), int'(exp_rc[1]));
      end
      if (run && bus.pred_req_valid) begin
        chk("p0_csb",  int'(sram_csb0),  0);
        chk("p0_web",  int'(sram_web0),  1);
        chk("p0_addr", int'(sram_addr0), int'(bus.pred_req_idx));
      end else begin
        chk("p0_idle", int'(sram_csb0), 1);
      end
      if (!run) begin
        if (edge_cnt >= 1 && edge_cnt <= 32) begin
          chk("init_csb",  int'(sram_csb1),  0);
          chk("init_web",  int'(sram_web1),  0);
          chk("init_addr", int'(sram_addr1), edge_cnt - 1);
          chk("init_din",  int'(sram_din1),  1);
        end else begin
          chk("init_p1_idle", int'(sram_csb1), 1);
        end
      end else if (acc_prev) begin
        chk("wr_csb",  int'(sram_csb1),  0);
        chk("wr_web",  int'(sram_web1),  0);
        chk("wr_addr", int'(sram_addr1), int'(prev_idx));
        chk("wr_din",  int'(sram_din1),  int'(model[prev_idx]));
      end else if (acc) begin
        chk("rd_csb",  int'(sram_csb1),  0);
        chk("rd_web",  int'(sram_web1),  1);
        chk("rd_addr", int'(sram_addr1), int'(bus.upd_idx));
      end else begin
        chk("p1_idle", int'(sram_csb1), 1);
      end
      // Prediction sees the table before this cycle's accepted update.
      exp_rv = run && bus.pred_req_valid;
      exp_rc = model[bus.pred_req_idx];
      if (acc) begin
        model[bus.upd_idx] = sat(model[bus.upd_idx], bus.upd_taken);
        prev_idx = bus.upd_idx;
      end
      acc_prev = acc;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_pred(input logic [4:0] idx, input int exp);
    bus.pred_req_valid = 1'b1;
    bus.pred_req_idx   = idx;
    tick();
    bus.pred_req_valid = 1'b0;
    @(negedge clk);
    chk("lit_pred_valid", int'(bus.pred_rsp_valid), 1);
    chk("lit_pred_ctr",   int'(bus.pred_rsp_ctr),   exp);
    tick();
  endtask

  task automatic do_upd(input logic [4:0] idx, input logic tk);
    int n = 0;
    while (!bus.upd_ready && n < 10) begin
      tick();
      n++;
    end
    chk("upd_ready_wait", int'(bus.upd_ready), 1);
    bus.upd_valid = 1'b1;
    bus.upd_idx   = idx;
    bus.upd_taken = tk;
    tick();
    bus.upd_valid = 1'b0;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!bus.init_done && n < 60) begin
      tick();
      n++;
    end
    chk("init_latency", n, 34);
  endtask

  initial begin
    int acc_cnt;
    rst_n = 1'b0;
    bus.pred_req_valid = 1'b0;
    bus.pred_req_idx   = '0;
    bus.upd_valid      = 1'b0;
    bus.upd_idx        = '0;
    bus.upd_taken      = 1'b0;
    repeat (3) tick();
    chk("lit_rst_init_done", int'(bus.init_done), 0);
    chk("lit_rst_upd_ready", int'(bus.upd_ready), 0);
    chk("lit_rst_csb1",      int'(sram_csb1),     1);
    rst_n = 1'b1;
    wait_init();

    // Freshly initialized entry
    bus.pred_req_valid = 1'b1;
    bus.pred_req_idx   = 5'd7;
    tick();
    bus.pred_req_valid = 1'b0;
    @(negedge clk);
    chk("lit_idx7_ctr",   int'(bus.pred_rsp_ctr),   1);
    chk("lit_idx7_taken", int'(bus.pred_rsp_taken), 0);
    tick();

    // Saturation at both ends
    repeat (3) do_upd(5'd3, 1'b1);
    do_pred(5'd3, 3);
    repeat (2) do_upd(5'd3, 1'b1);
    do_pred(5'd3, 3);
    repeat (4) do_upd(5'd3, 1'b0);
    do_pred(5'd3, 0);

    // Same-cycle predict sees old value; next-cycle predict sees new value
    bus.upd_valid      = 1'b1;
    bus.upd_idx        = 5'd5;
    bus.upd_taken      = 1'b1;
    bus.pred_req_valid = 1'b1;
    bus.pred_req_idx   = 5'd5;
    tick();
    bus.upd_valid = 1'b0;
    @(negedge clk);
    chk("lit_fwd_same_cycle", int'(bus.pred_rsp_ctr), 1);
    tick();
    @(negedge clk);
    chk("lit_fwd_next_cycle", int'(bus.pred_rsp_ctr), 2);
    tick();
    bus.pred_req_valid = 1'b0;
    @(negedge clk);
    chk("lit_fwd_macro_path", int'(bus.pred_rsp_ctr), 2);
    tick();
    tick();

    // Back-to-back update requests: ready alternates
    acc_cnt = 0;
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 5'd12;
    bus.upd_taken = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("lit_ready_toggle", int'(bus.upd_ready), (i % 2 == 0) ? 1 : 0);
      if (bus.upd_ready) acc_cnt++;
      tick();
    end
    bus.upd_valid = 1'b0;
    chk("lit_accept_count", acc_cnt, 3);
    do_pred(5'd12, 3);

    // Randomized traffic, biased toward a few indices for collisions
    for (int c = 0; c < 1500; c++) begin
      bus.pred_req_valid = 1'($urandom_range(0, 1));
      bus.pred_req_idx   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7))
                                                       : 5'($urandom_range(0, 31));
      bus.upd_valid      = 1'($urandom_range(0, 1));
      bus.upd_idx        = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7))
                                                       : 5'($urandom_range(0, 31));
      bus.upd_taken      = 1'($urandom_range(0, 1));
      tick();
    end
    bus.pred_req_valid = 1'b0;
    bus.upd_valid      = 1'b0;
    repeat (2) tick();

    // Reset while a write-back is pending
    do_upd(5'd20, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("lit_midrst_upd_ready", int'(bus.upd_ready),      0);
    chk("lit_midrst_init_done", int'(bus.init_done),      0);
    chk("lit_midrst_rsp_valid", int'(bus.pred_rsp_valid), 0);
    chk("lit_midrst_csb1",      int'(sram_csb1),          1);
    chk("lit_midrst_web1",      int'(sram_web1),          1);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_init();
    for (int i = 0; i < 32; i++) do_pred(5'(i), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
